// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture datapath: default widths
// used by the capture engine and the DRAM packer, plus small sizing helpers.
package la_pkg;

    localparam int SAMPLE_W_DEF   = 32;
    localparam int DRAM_W_DEF     = 128;
    localparam int ADX_W_DEF      = 27;
    localparam int ADX_STEP_DEF   = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of samples that fit in one DRAM word.
    function automatic int lanes(input int sample_w, input int dram_w);
        return dram_w / sample_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count. Push and pop may occur
// in the same cycle; a push into a full FIFO is accepted only if a pop frees a
// slot on the same edge, otherwise the word is ignored.
module sync_fifo
    import la_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy registers; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count/empty flag
        // gates every use of its contents, and leaving it unreset lets it map to RAM.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs SAMPLE_W-bit capture samples into DRAM_W-bit words, tags each word with
// a linear or ring-buffer DRAM address and queues it for the DDR interface.
module sample_packer
    import la_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int DRAM_W     = DRAM_W_DEF,
    parameter int ADX_W      = ADX_W_DEF,
    parameter int ADX_STEP   = ADX_STEP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        we,
    input  logic [SAMPLE_W-1:0]                         write_data,
    input  logic                                        flush,
    input  logic [ADX_W-1:0]                            base_adx,
    input  logic [ADX_W-1:0]                            wrap_words,
    input  logic                                        write_allowed,
    output logic [DRAM_W-1:0]                           dram_data,
    output logic [ADX_W-1:0]                            dram_adx,
    output logic                                        write_req,
    output logic                                        pageFull,
    output logic [clog2(lanes(SAMPLE_W, DRAM_W)+1)-1:0] last_lanes,
    output logic [31:0]                                 words_written,
    output logic                                        overflow
);

    localparam int LANES = lanes(SAMPLE_W, DRAM_W);
    localparam int LL_W  = clog2(LANES + 1);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DRAM_W + ADX_W;

    localparam logic [LL_W-1:0] LAST_LANE  = LL_W'(LANES - 1);
    localparam logic [LL_W-1:0] FULL_LANES = LL_W'(LANES);

    // Packing state
    logic [LL_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [DRAM_W-1:0] acc_q, acc_d;
    // Address generator state
    logic [ADX_W-1:0]  adx_q, adx_d;
    logic [ADX_W-1:0]  base_q, base_d;
    logic [ADX_W-1:0]  wcnt_q, wcnt_d;
    // Status
    logic [LL_W-1:0]   last_lanes_q, last_lanes_d;
    logic [31:0]       words_q, words_d;
    logic              overflow_q, overflow_d;

    // Combinational helpers
    logic [DRAM_W-1:0] word_next;
    logic [LL_W-1:0]   lanes_after;
    logic              word_done, flush_push, push, idle;
    logic [ADX_W-1:0]  cur_adx, cur_base, cur_wcnt;

    // FIFO interface
    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({cur_adx, word_next}),
        .pop_i   (write_req),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // The reset cycle never issues a write, whatever the FIFO held before it.
    assign write_req     = !fifo_empty && write_allowed && !reset;
    assign pageFull      = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign dram_data     = fifo_empty ? '0 : fifo_head[DRAM_W-1:0];
    assign dram_adx      = fifo_empty ? '0 : fifo_head[ENT_W-1:DRAM_W];
    assign last_lanes    = last_lanes_q;
    assign words_written = words_q;
    assign overflow      = overflow_q;

    // Lane packing, push decision, address generation and status next-state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        word_next    = acc_q;
        lanes_after  = lane_cnt_q + LL_W'(we);
        word_done    = we && (lane_cnt_q == LAST_LANE);
        flush_push   = flush && ((lane_cnt_q != '0) || we);
        push         = word_done || flush_push;
        idle         = (lane_cnt_q == '0) && fifo_empty;

        // While idle the generator follows base_adx so the next stream starts there.
        cur_adx      = idle ? base_adx : adx_q;
        cur_base     = idle ? base_adx : base_q;
        cur_wcnt     = idle ? '0 : wcnt_q;

        lane_cnt_d   = lane_cnt_q;
        acc_d        = acc_q;
        adx_d        = cur_adx;
        base_d       = cur_base;
        wcnt_d       = cur_wcnt;
        last_lanes_d = last_lanes_q;
        words_d      = words_q;
        overflow_d   = overflow_q;

        if (we) begin
            word_next[int'(lane_cnt_q) * SAMPLE_W +: SAMPLE_W] = write_data;
        end

        if (push) begin
            // Unfilled upper lanes of the accumulator are already zero.
            lane_cnt_d   = '0;
            acc_d        = '0;
            last_lanes_d = word_done ? FULL_LANES : lanes_after;
            if ((wrap_words != '0) && (cur_wcnt + ADX_W'(1) == wrap_words)) begin
                adx_d  = cur_base;
                wcnt_d = '0;
            end else begin
                adx_d  = cur_adx + ADX_W'(ADX_STEP);
                wcnt_d = cur_wcnt + ADX_W'(1);
            end
            // A full FIFO with no pop this edge drops the word; the address still moves on.
            if (fifo_full && !write_req) begin
                overflow_d = 1'b1;
            end
        end else if (we) begin
            lane_cnt_d = lanes_after;
            acc_d      = word_next;
        end

        if (write_req) begin
            words_d = words_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_cnt_q   <= '0;
            acc_q        <= '0;
            adx_q        <= base_adx;
            base_q       <= base_adx;
            wcnt_q       <= '0;
            last_lanes_q <= '0;
            words_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            acc_q        <= acc_d;
            adx_q        <= adx_d;
            base_q       <= base_d;
            wcnt_q       <= wcnt_d;
            last_lanes_q <= last_lanes_d;
            words_q      <= words_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule
